// File: rtl/psum_collector.sv
// Collects partial sums from NUM_COL PE ports (round-robin) into a FWFT FIFO and emits an addressed write stream.
// Optional back-pressure statistics counter enabled by defining PSUM_COLLECT_STATS_EN.
module psum_collector #(
    parameter int DATA_WIDTH  = 16,
    parameter int NUM_COL     = 10,
    parameter int BUFFER_SIZE = 512,
    parameter int FIFO_DEPTH  = 16,
    localparam int AW  = $clog2(BUFFER_SIZE),
    localparam int PW  = 2 * DATA_WIDTH,
    localparam int IDW = $clog2(NUM_COL) + 1
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  start,
    input  logic [AW-1:0]         base_addr,
    input  logic [AW:0]           num_psum,
    input  logic [NUM_COL-1:0]    pe_valid,
    input  logic [NUM_COL*PW-1:0] pe_data,
    output logic [NUM_COL-1:0]    pe_ready,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [PW-1:0]         out_data,
    output logic [AW-1:0]         out_addr,
    output logic [IDW-1:0]        out_id,
    output logic                  busy,
    output logic                  done,
    output logic [15:0]           stall_cnt
);
    localparam int CW  = $clog2(NUM_COL);
    localparam int FAW = $clog2(FIFO_DEPTH);
    localparam int EW  = PW + IDW;

    typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_FLUSH, S_DONE} state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] base_q, base_d;
    logic [AW:0]   num_q, num_d;
    logic [AW:0]   in_cnt_q, in_cnt_d;
    logic [AW-1:0] out_cnt_q, out_cnt_d;
    logic [CW-1:0] rr_q, rr_d;
    logic [FAW:0]  wr_q, rd_q;
    logic [EW-1:0] mem_q [FIFO_DEPTH];

    logic          full, empty, push, pop;
    logic          grant_vld;
    logic [CW-1:0] grant_idx;
    logic [PW-1:0] grant_data;
    logic [EW-1:0] head;

    assign empty = (wr_q == rd_q);
    assign full  = (wr_q[FAW-1:0] == rd_q[FAW-1:0]) && (wr_q[FAW] != rd_q[FAW]);

    // Cyclic search from rr_q+1: columns above the pointer first, then wrap to 0..rr_q.
    always_comb begin
        grant_vld  = 1'b0;
        grant_idx  = '0;
        grant_data = '0;
        if (state_q == S_DRAIN && !full) begin
            for (int c = 0; c < NUM_COL; c++) begin
                if (!grant_vld && c > int'(rr_q) && pe_valid[c]) begin
                    grant_vld  = 1'b1;
                    grant_idx  = CW'(c);
                    grant_data = pe_data[c*PW +: PW];
                end
            end
            for (int c = 0; c < NUM_COL; c++) begin
                if (!grant_vld && c <= int'(rr_q) && pe_valid[c]) begin
                    grant_vld  = 1'b1;
                    grant_idx  = CW'(c);
                    grant_data = pe_data[c*PW +: PW];
                end
            end
        end
    end

    assign pe_ready = grant_vld ? (NUM_COL'(1) << grant_idx) : '0;
    assign push     = grant_vld;
    assign pop      = !empty && out_ready;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (push) wr_q <= wr_q + 1'b1;
            if (pop)  rd_q <= rd_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q[FAW-1:0]] <= {grant_data, 1'b0, grant_idx};
    end

    assign head      = mem_q[rd_q[FAW-1:0]];
    assign out_valid = !empty;
    assign out_data  = empty ? '0 : head[EW-1:IDW];
    assign out_id    = empty ? '0 : head[IDW-1:0];
    assign out_addr  = base_q + out_cnt_q;
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);

    always_comb begin
        state_d   = state_q;
        base_d    = base_q;
        num_d     = num_q;
        in_cnt_d  = in_cnt_q;
        out_cnt_d = pop ? out_cnt_q + 1'b1 : out_cnt_q;
        rr_d      = grant_vld ? grant_idx : rr_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    base_d    = base_addr;
                    num_d     = num_psum;
                    in_cnt_d  = '0;
                    out_cnt_d = '0;
                    state_d   = (num_psum == '0) ? S_DONE : S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (push) begin
                    in_cnt_d = in_cnt_q + 1'b1;
                    if (in_cnt_d == num_q) state_d = S_FLUSH;
                end
            end
            S_FLUSH: if (empty) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= S_IDLE;
            base_q    <= '0;
            num_q     <= '0;
            in_cnt_q  <= '0;
            out_cnt_q <= '0;
            rr_q      <= CW'(NUM_COL - 1);
        end else begin
            state_q   <= state_d;
            base_q    <= base_d;
            num_q     <= num_d;
            in_cnt_q  <= in_cnt_d;
            out_cnt_q <= out_cnt_d;
            rr_q      <= rr_d;
        end
    end

`ifdef PSUM_COLLECT_STATS_EN
    logic [15:0] stall_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stall_q <= '0;
        end else if (state_q == S_IDLE && start) begin
            stall_q <= '0;
        end else if (busy && !empty && !out_ready && stall_q != 16'hFFFF) begin
            stall_q <= stall_q + 1'b1;
        end
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = '0;
`endif

endmodule
